// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and constants for the MEM/WB writeback stage:
//                result-source encoding, load funct3 codes, and the
//                stage-register layout.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // Result-source select; 2'b11 is reserved and behaves like RES_ALU
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // result_src is kept as raw bits so the reserved code can be held as-is
  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic [WB_ADDR_W-1:0] rd;
    logic [1:0]           result_src;
    logic [2:0]           funct3;
    logic [WB_DATA_W-1:0] alu_result;
    logic [WB_DATA_W-1:0] pc_plus4;
    logic [WB_DATA_W-1:0] read_data;
    logic                 fresh;
  } wb_stage_t;

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_extend
//  Description : Combinational load aligner. Picks the byte/half/word at the
//                effective-address offset from the raw memory word, applies
//                sign or zero extension, and flags misaligned or undefined
//                load encodings.
//  Revision    : 1.0  initial release
// ============================================================================
module load_extend
  import wb_pkg::*;
(
  input  logic [WB_DATA_W-1:0] raw,
  input  logic [1:0]           offset,
  input  logic [2:0]           funct3,
  output logic [WB_DATA_W-1:0] data,
  output logic                 fault
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane select: byte by full offset, half by offset[1]
  always_comb begin
    sel_byte = raw[7:0];
    case (offset)
      2'd0: sel_byte = raw[7:0];
      2'd1: sel_byte = raw[15:8];
      2'd2: sel_byte = raw[23:16];
      2'd3: sel_byte = raw[31:24];
      default: sel_byte = raw[7:0];
    endcase
    sel_half = offset[1] ? raw[31:16] : raw[15:0];
  end

  // Extension and alignment check; undefined funct3 codes always fault
  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB: begin
        data = {{(WB_DATA_W-8){sel_byte[7]}}, sel_byte};
      end
      F3_LBU: begin
        data = {{(WB_DATA_W-8){1'b0}}, sel_byte};
      end
      F3_LH: begin
        data  = {{(WB_DATA_W-16){sel_half[15]}}, sel_half};
        fault = offset[0];
      end
      F3_LHU: begin
        data  = {{(WB_DATA_W-16){1'b0}}, sel_half};
        fault = offset[0];
      end
      F3_LW: begin
        data  = raw;
        fault = (offset != 2'b00);
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_stage
//  Description : MEM/WB pipeline register plus result select. Holds one
//                memory-stage result, produces the register-file write port
//                (AD3/WE3/WD3), forwarding data, a load-fault pulse and the
//                retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              m_valid,
  input  logic              m_reg_write,
  input  logic [ADDR_W-1:0] m_rd,
  input  logic [1:0]        m_result_src,
  input  logic [2:0]        m_funct3,
  input  logic [DATA_W-1:0] m_alu_result,
  input  logic [DATA_W-1:0] m_pc_plus4,
  input  logic [DATA_W-1:0] m_read_data,
  output logic [ADDR_W-1:0] AD3,
  output logic              WE3,
  output logic [DATA_W-1:0] WD3,
  output logic [ADDR_W-1:0] wb_rd,
  output logic              wb_fwd_valid,
  output logic              load_fault,
  output logic [31:0]       instret
);

  wb_stage_t         stage;
  logic [31:0]       retired;
  logic [DATA_W-1:0] load_data;
  logic              load_bad;
  logic              is_load;
  logic              fault;
  logic              writes_rd;
  logic              first_cycle;

  load_extend u_load_extend (
    .raw    (stage.read_data),
    .offset (stage.alu_result[1:0]),
    .funct3 (stage.funct3),
    .data   (load_data),
    .fault  (load_bad)
  );

  // Stage register: flush beats stall; a stall keeps the entry but marks it
  // as already seen so it cannot write or retire twice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else if (stall_i) begin
      stage.valid <= stage.valid & ~flush_i;
      stage.fresh <= 1'b0;
    end else begin
      stage.valid      <= m_valid & ~flush_i;
      stage.fresh      <= ~flush_i;
      stage.reg_write  <= m_reg_write;
      stage.rd         <= m_rd;
      stage.result_src <= m_result_src;
      stage.funct3     <= m_funct3;
      stage.alu_result <= m_alu_result;
      stage.pc_plus4   <= m_pc_plus4;
      stage.read_data  <= m_read_data;
    end
  end

  // Decode the held entry: fault only applies to loads
  always_comb begin
    is_load     = (stage.result_src == RES_LOAD);
    fault       = is_load & load_bad;
    first_cycle = stage.valid & stage.fresh;
    writes_rd   = stage.valid & stage.reg_write & (stage.rd != '0) & ~fault;
  end

  // Result select; reserved result_src falls through to the ALU value
  always_comb begin
    case (stage.result_src)
      RES_LOAD: WD3 = load_data;
      RES_PC4:  WD3 = stage.pc_plus4;
      default:  WD3 = stage.alu_result;
    endcase
  end

  // Write port and forwarding; forwarding stays up across stalls
  always_comb begin
    AD3          = stage.rd;
    wb_rd        = stage.rd;
    WE3          = writes_rd & stage.fresh;
    wb_fwd_valid = writes_rd;
    load_fault   = first_cycle & fault;
    instret      = retired;
  end

  // Retire counter: one count per entry, on its first cycle, unless faulted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (first_cycle & ~fault) begin
      retired <= retired + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_stage
//  Description : Self-checking bench for writeback_stage. Directed scenarios
//                plus randomized traffic compared against a transaction-level
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_stage;

  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i;
  logic        m_valid, m_reg_write;
  logic [4:0]  m_rd;
  logic [1:0]  m_result_src;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu_result, m_pc_plus4, m_read_data;
  logic [4:0]  AD3, wb_rd;
  logic        WE3, wb_fwd_valid, load_fault;
  logic [31:0] WD3, instret;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: the entry held in the stage and whether it is new
  logic        mv_have, mv_fresh;
  txn_t        mv_t;
  logic [31:0] exp_instret;

  writeback_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .m_valid      (m_valid),
    .m_reg_write  (m_reg_write),
    .m_rd         (m_rd),
    .m_result_src (m_result_src),
    .m_funct3     (m_funct3),
    .m_alu_result (m_alu_result),
    .m_pc_plus4   (m_pc_plus4),
    .m_read_data  (m_read_data),
    .AD3          (AD3),
    .WE3          (WE3),
    .WD3          (WD3),
    .wb_rd        (wb_rd),
    .wb_fwd_valid (wb_fwd_valid),
    .load_fault   (load_fault),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  function automatic txn_t mk(input logic v, input logic rw, input logic [4:0] rd,
                              input logic [1:0] src, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] rdata);
    txn_t t;
    t.valid = v; t.rw = rw; t.rd = rd; t.src = src; t.f3 = f3;
    t.alu = alu; t.pc4 = pc4; t.rdata = rdata;
    return t;
  endfunction

  // A load faults on undefined funct3 or when the access is not naturally aligned
  function automatic logic m_fault(input txn_t t);
    int unsigned off;
    off = t.alu % 4;
    if (t.src != 2'd1) return 1'b0;
    case (t.f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (off % 2) != 0;
      3'd2:       return off != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input txn_t t);
    int unsigned off;
    logic [31:0] v;
    off = t.alu % 4;
    if (t.src == 2'd2) return t.pc4;
    if (t.src != 2'd1) return t.alu;
    case (t.f3)
      3'd0: begin v = (t.rdata >> (8 * off)) & 32'hFF;
                  return (v >= 32'd128) ? v + 32'hFFFF_FF00 : v; end
      3'd4: return (t.rdata >> (8 * off)) & 32'hFF;
      3'd1: begin v = (t.rdata >> (16 * (off / 2))) & 32'hFFFF;
                  return (v >= 32'd32768) ? v + 32'hFFFF_0000 : v; end
      3'd5: return (t.rdata >> (16 * (off / 2))) & 32'hFFFF;
      default: return t.rdata;
    endcase
  endfunction

  function automatic logic m_writes(input txn_t t);
    return t.rw && (t.rd != 5'd0) && !m_fault(t);
  endfunction

  task automatic model_reset();
    mv_have = 1'b0; mv_fresh = 1'b0; exp_instret = 32'd0;
    mv_t = mk(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1 ns later
  task automatic cycle(input logic st, input logic fl, input txn_t t);
    stall_i = st; flush_i = fl;
    m_valid = t.valid; m_reg_write = t.rw; m_rd = t.rd; m_result_src = t.src;
    m_funct3 = t.f3; m_alu_result = t.alu; m_pc_plus4 = t.pc4; m_read_data = t.rdata;
    @(posedge clk);
    if (mv_have && mv_fresh && !m_fault(mv_t)) exp_instret = exp_instret + 32'd1;
    if (!st) begin
      mv_t = t; mv_have = t.valid && !fl; mv_fresh = !fl;
    end else begin
      mv_have = mv_have && !fl; mv_fresh = 1'b0;
    end
    #1;
  endtask

  function automatic txn_t bubble();
    return mk(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
  endfunction

  task automatic test_reset();
    total_cnt++; if (WE3 !== 1'b0) $display("FAIL reset_we3 got %b want 0", WE3); else pass_cnt++;
    total_cnt++; if (AD3 !== 5'd0) $display("FAIL reset_ad3 got %0d want 0", AD3); else pass_cnt++;
    total_cnt++; if (WD3 !== 32'd0) $display("FAIL reset_wd3 got %h want 0", WD3); else pass_cnt++;
    total_cnt++; if (wb_fwd_valid !== 1'b0) $display("FAIL reset_fwd got %b want 0", wb_fwd_valid); else pass_cnt++;
    total_cnt++; if (load_fault !== 1'b0) $display("FAIL reset_fault got %b want 0", load_fault); else pass_cnt++;
    total_cnt++; if (instret !== 32'd0) $display("FAIL reset_instret got %h want 0", instret); else pass_cnt++;
  endtask

  task automatic test_loads();
    cycle(1'b0, 1'b0, mk(1'b1, 1'b1, 5'd7, 2'd1, 3'd0, 32'h101, 32'h0, 32'h1234_80FF));
    total_cnt++; if (WE3 !== 1'b1) $display("FAIL lb_we3 got %b want 1", WE3); else pass_cnt++;
    total_cnt++; if (AD3 !== 5'd7) $display("FAIL lb_ad3 got %0d want 7", AD3); else pass_cnt++;
    total_cnt++; if (WD3 !== 32'hFFFF_FF80) $display("FAIL lb_wd3 got %h want ffffff80", WD3); else pass_cnt++;
    total_cnt++; if (instret !== 32'd0) $display("FAIL lb_instret_before got %h want 0", instret); else pass_cnt++;
    cycle(1'b0, 1'b0, mk(1'b1, 1'b1, 5'd8, 2'd1, 3'd5, 32'h102, 32'h0, 32'h1234_80FF));
    total_cnt++; if (instret !== 32'd1) $display("FAIL lb_instret_after got %h want 1", instret); else pass_cnt++;
    total_cnt++; if (WD3 !== 32'h0000_1234) $display("FAIL lhu_wd3 got %h want 00001234", WD3); else pass_cnt++;
    cycle(1'b0, 1'b0, mk(1'b1, 1'b1, 5'd9, 2'd1, 3'd1, 32'h100, 32'h0, 32'h1234_80FF));
    total_cnt++; if (WD3 !== 32'hFFFF_80FF) $display("FAIL lh_wd3 got %h want ffff80ff", WD3); else pass_cnt++;
    total_cnt++; if (WE3 !== 1'b1) $display("FAIL lh_we3 got %b want 1", WE3); else pass_cnt++;
  endtask

  task automatic test_rd_zero();
    logic [31:0] base;
    cycle(1'b0, 1'b0, mk(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0));
    base = exp_instret;
    total_cnt++; if (WE3 !== 1'b0) $display("FAIL rd0_we3 got %b want 0", WE3); else pass_cnt++;
    total_cnt++; if (wb_fwd_valid !== 1'b0) $display("FAIL rd0_fwd got %b want 0", wb_fwd_valid); else pass_cnt++;
    cycle(1'b0, 1'b0, bubble());
    total_cnt++; if (instret !== base + 32'd1) $display("FAIL rd0_instret got %h want %h", instret, base + 32'd1); else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [31:0] base;
    int we_hits;
    base = exp_instret;
    we_hits = 0;
    cycle(1'b0, 1'b0, mk(1'b1, 1'b1, 5'd1, 2'd2, 3'd0, 32'h0, 32'h40, 32'h0));
    for (int i = 0; i < 4; i++) begin
      if (WE3 === 1'b1) we_hits++;
      total_cnt++; if (WD3 !== 32'h40) $display("FAIL stall_wd3[%0d] got %h want 40", i, WD3); else pass_cnt++;
      total_cnt++; if (wb_fwd_valid !== 1'b1) $display("FAIL stall_fwd[%0d] got %b want 1", i, wb_fwd_valid); else pass_cnt++;
      if (i < 3) cycle(1'b1, 1'b0, mk(1'b1, 1'b1, 5'd30, 2'd0, 3'd0, $urandom, 32'h0, 32'h0));
    end
    total_cnt++; if (we_hits != 1) $display("FAIL stall_we3_pulses got %0d want 1", we_hits); else pass_cnt++;
    total_cnt++; if (instret !== base + 32'd1) $display("FAIL stall_instret got %h want %h", instret, base + 32'd1); else pass_cnt++;
  endtask

  task automatic test_fault();
    logic [31:0] base;
    cycle(1'b0, 1'b0, bubble());
    base = exp_instret;
    cycle(1'b0, 1'b0, mk(1'b1, 1'b1, 5'd3, 2'd1, 3'd2, 32'h102, 32'h0, 32'hCAFE_F00D));
    total_cnt++; if (WE3 !== 1'b0) $display("FAIL lw_mis_we3 got %b want 0", WE3); else pass_cnt++;
    total_cnt++; if (load_fault !== 1'b1) $display("FAIL lw_mis_fault got %b want 1", load_fault); else pass_cnt++;
    cycle(1'b0, 1'b0, bubble());
    total_cnt++; if (load_fault !== 1'b0) $display("FAIL lw_mis_pulse got %b want 0", load_fault); else pass_cnt++;
    total_cnt++; if (instret !== base) $display("FAIL lw_mis_instret got %h want %h", instret, base); else pass_cnt++;
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b0, mk(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0));
    total_cnt++; if (WE3 !== 1'b1) $display("FAIL flush_pre_we3 got %b want 1", WE3); else pass_cnt++;
    cycle(1'b1, 1'b1, mk(1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 32'h66, 32'h0, 32'h0));
    total_cnt++; if (WE3 !== 1'b0) $display("FAIL flush_stall_we3 got %b want 0", WE3); else pass_cnt++;
    total_cnt++; if (wb_fwd_valid !== 1'b0) $display("FAIL flush_stall_fwd got %b want 0", wb_fwd_valid); else pass_cnt++;
    cycle(1'b0, 1'b1, mk(1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 32'h66, 32'h0, 32'h0));
    total_cnt++; if (WE3 !== 1'b0) $display("FAIL flush_we3 got %b want 0", WE3); else pass_cnt++;
  endtask

  task automatic test_instret_wrap();
    cycle(1'b0, 1'b0, bubble());
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    exp_instret = 32'hFFFF_FFFF;
    cycle(1'b0, 1'b0, mk(1'b1, 1'b0, 5'd2, 2'd0, 3'd0, 32'h1, 32'h0, 32'h0));
    cycle(1'b0, 1'b0, bubble());
    total_cnt++; if (instret !== 32'd0) $display("FAIL instret_wrap got %h want 0", instret); else pass_cnt++;
  endtask

  task automatic test_random();
    txn_t t;
    logic st, fl;
    logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 300; i++) begin
      t.valid = ($urandom_range(0, 9) < 8);
      t.rw    = ($urandom_range(0, 9) < 8);
      t.rd    = 5'($urandom_range(0, 31));
      t.src   = 2'($urandom_range(0, 3));
      t.f3    = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      t.alu   = $urandom;
      t.pc4   = $urandom;
      t.rdata = $urandom;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      cycle(st, fl, t);
      total_cnt++;
      if (WE3 !== (mv_have && mv_fresh && m_writes(mv_t)))
        $display("FAIL rnd_we3[%0d] got %b want %b", i, WE3, mv_have && mv_fresh && m_writes(mv_t));
      else pass_cnt++;
      total_cnt++;
      if (wb_fwd_valid !== (mv_have && m_writes(mv_t)))
        $display("FAIL rnd_fwd[%0d] got %b want %b", i, wb_fwd_valid, mv_have && m_writes(mv_t));
      else pass_cnt++;
      total_cnt++;
      if (load_fault !== (mv_have && mv_fresh && m_fault(mv_t)))
        $display("FAIL rnd_fault[%0d] got %b want %b", i, load_fault, mv_have && mv_fresh && m_fault(mv_t));
      else pass_cnt++;
      total_cnt++;
      if (instret !== exp_instret) $display("FAIL rnd_instret[%0d] got %h want %h", i, instret, exp_instret);
      else pass_cnt++;
      if (mv_have) begin
        total_cnt++;
        if (AD3 !== mv_t.rd || wb_rd !== mv_t.rd)
          $display("FAIL rnd_rd[%0d] got %0d/%0d want %0d", i, AD3, wb_rd, mv_t.rd);
        else pass_cnt++;
        if (!m_fault(mv_t)) begin
          total_cnt++;
          if (WD3 !== m_wd(mv_t)) $display("FAIL rnd_wd3[%0d] got %h want %h", i, WD3, m_wd(mv_t));
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b0, mk(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0));
    total_cnt++; if (WE3 !== 1'b1) $display("FAIL arst_pre_we3 got %b want 1", WE3); else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    total_cnt++; if (WE3 !== 1'b0) $display("FAIL arst_we3 got %b want 0", WE3); else pass_cnt++;
    total_cnt++; if (AD3 !== 5'd0 || wb_rd !== 5'd0) $display("FAIL arst_rd got %0d/%0d want 0", AD3, wb_rd); else pass_cnt++;
    total_cnt++; if (WD3 !== 32'd0) $display("FAIL arst_wd3 got %h want 0", WD3); else pass_cnt++;
    total_cnt++; if (wb_fwd_valid !== 1'b0) $display("FAIL arst_fwd got %b want 0", wb_fwd_valid); else pass_cnt++;
    total_cnt++; if (instret !== 32'd0) $display("FAIL arst_instret got %h want 0", instret); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (instret !== 32'd0) $display("FAIL arst_hold_instret got %h want 0", instret); else pass_cnt++;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0; flush_i = 1'b0;
    m_valid = 1'b0; m_reg_write = 1'b0; m_rd = '0; m_result_src = '0; m_funct3 = '0;
    m_alu_result = '0; m_pc_plus4 = '0; m_read_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_loads();
    test_rd_zero();
    test_stall();
    test_fault();
    test_flush();
    test_instret_wrap();
    test_random();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
